mod_iface_sink: RTL and testbench
=================================

# mod_iface_sink

Receive-side counterpart to the `my_interface` driver end: consumes the `WIDTH`-bit data word the interface presents on its `data` line, qualified by a valid strobe. Buffers accepted words in a small first-word-fall-through FIFO and hands them downstream over a valid/ready handshake. Words that arrive while the buffer is full are dropped, counted, and flagged, so the producer side never stalls. Sits directly behind an `my_interface` instance, one per interface.

## Interface

Parameters:
- `WIDTH`, default 8: data word width; matches the interface `WIDTH`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.

Ports:
- `i_clk`, input, 1: sole clock; everything is sampled on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_data`, input, `WIDTH`: word from the interface `data` line.
- `i_valid`, input, 1: `i_data` is valid this cycle.
- `o_ready`, output, 1: space available; equals `!full`.
- `o_data`, output, `WIDTH`: head-of-FIFO word.
- `o_valid`, output, 1: `o_data` is valid; equals `!empty`.
- `i_ready`, input, 1: downstream accepts `o_data` this cycle.
- `o_level`, output, `$clog2(DEPTH+1)`: current occupancy, 0..`DEPTH`.
- `o_overflow`, output, 1: sticky drop flag.
- `o_drop_cnt`, output, 8: number of dropped words; saturates at 255.
- `i_ovf_clr`, input, 1: single-cycle pulse that clears `o_overflow` and `o_drop_cnt`.

## Operation

Storage:
- `DEPTH` × `WIDTH` memory.
- Read and write pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB is the wrap bit.
- empty: pointers are equal.
- full: index bits are equal and wrap bits differ.
- Pointers wrap modulo `2*DEPTH`.

Write (push): `i_valid && !full`. Stores `i_data` at the write pointer and increments the write pointer.

Drop: `i_valid && full`.
- Nothing is stored.
- `o_overflow` is set to 1.
- `o_drop_cnt` increments, saturating at 255.
- Fullness is judged from the registered state at the start of the cycle. A pop in the same cycle does not rescue the word; it is still dropped.

Read (pop): `o_valid && i_ready`. Increments the read pointer. `i_ready` while empty has no effect.

Simultaneous push and pop on a non-empty, non-full FIFO: both happen and `o_level` is unchanged.

Output data:
- `o_data = mem[rd_ptr]` when `o_valid = 1`.
- `o_data` is forced to 0 when empty.

Occupancy: `o_level = wr_ptr - rd_ptr`, computed modulo `2*DEPTH`.

`i_ovf_clr`:
- Clears `o_overflow` to 0 and `o_drop_cnt` to 0.
- If a drop occurs in the same cycle, the drop wins: `o_overflow = 1`, `o_drop_cnt = 1`.

`o_ready` does not depend on `i_ready`, so there is no combinational path from downstream to upstream.

## Timing

- Reset (asynchronous assert, synchronous-edge release):
  - Both pointers are 0.
  - `o_valid = 0`, `o_ready = 1`, `o_data = 0`, `o_level = 0`, `o_overflow = 0`, `o_drop_cnt = 0`.
  - Memory contents need no reset.
- Reset asserted mid-operation discards all buffered words immediately, with no further handshakes.
- Latency: a word pushed at edge N is visible on `o_data`/`o_valid` after edge N, so the fall-through latency is one cycle.
- Throughput: one push and one pop per cycle, sustained.
- `o_ready`, `o_valid`, `o_level`, `o_overflow` and `o_drop_cnt` are all functions of registered state only.
- `o_data` is a memory read at the registered pointer and changes only after a clock edge.
- Order is strictly FIFO. No word is duplicated; a word is lost only through a counted drop.

## Test plan

1. **Reset and single word.** Release reset, push 0xA5 for one cycle with `i_ready = 0`.
   - Next cycle: `o_valid = 1`, `o_data = 0xA5`, `o_level = 1`.
   - Then pulse `i_ready`: `o_valid = 0`, `o_data = 0`, `o_level = 0`.
2. **Fill to full.** Push 0x01..0x04 with `i_ready = 0` (`DEPTH` = 4).
   - `o_ready = 0` and `o_level = 4`.
   - Push 0x05: `o_overflow = 1`, `o_drop_cnt = 1`.
   - Drain: outputs are exactly 0x01, 0x02, 0x03, 0x04.
3. **Push at full with a same-cycle pop.** From full, push 0x99 while popping.
   - 0x99 is dropped and `o_drop_cnt` increments.
   - `o_level` becomes 3.
4. **Streaming.**
   - 20 consecutive pushes of 0x10..0x23 with `i_ready = 1`: every word comes out in order, one cycle later.
   - `o_level` stays ≤ 1 throughout and there are no drops.
   - This exercises pointer wrap more than twice.
5. **Saturation and clear.**
   - Hold full and push 260 times: `o_drop_cnt = 255`.
   - Pulse `i_ovf_clr` with no drop: both clear to 0.
   - Pulse `i_ovf_clr` together with a drop: `o_overflow = 1`, `o_drop_cnt = 1`.
6. **Reset mid-stream.** Assert `i_rst_n = 0` asynchronously with 3 words buffered.
   - `o_valid = 0` and `o_level = 0` immediately, without waiting for a clock edge.
   - After release, the first push returns only the new word.

Source files
------------

// File: rtl/mod_iface_sink.sv
// Receive-side sink for one my_interface: valid-qualified words enter a small
// first-word-fall-through FIFO; words arriving while full are dropped and counted.
module mod_iface_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_overflow,
    output logic [7:0]                   o_drop_cnt,
    input  logic                         i_ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic          empty, full, push, pop, drop;
    logic [PW-1:0] level;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Fullness comes from registered state only, so a same-cycle pop cannot rescue a word.
    assign push = i_valid && !full;
    assign drop = i_valid && full;
    assign pop  = !empty && i_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = i_ovf_clr ? 8'd1 :
                         (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
        end else if (i_ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    assign level      = wr_ptr_q - rd_ptr_q;
    assign o_level    = LW'(level);
    assign o_ready    = !full;
    assign o_valid    = !empty;
    assign o_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_overflow = ovf_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mod_iface_sink.sv
// Directed bench for mod_iface_sink (WIDTH=8, DEPTH=4): hand-computed expectations
// for reset, fill/drain, drop-on-full, streaming, saturation/clear and async reset.
module tb_mod_iface_sink;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_level;
    logic       o_overflow;
    logic [7:0] o_drop_cnt;
    logic       i_ovf_clr;

    int errors = 0;
    int checks = 0;

    mod_iface_sink #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt),
        .i_ovf_clr  (i_ovf_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_data    = 8'h00;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_ovf_clr = 1'b0;
        #1;

        // 1. Reset state and a single word
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_data", o_data, 0);
        check("rst_level", o_level, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_drop", o_drop_cnt, 0);
        step();
        step();
        i_rst_n = 1'b1;
        step();

        push_word(8'hA5);
        check("t1_valid", o_valid, 1);
        check("t1_data", o_data, 8'hA5);
        check("t1_level", o_level, 1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("t1_pop_valid", o_valid, 0);
        check("t1_pop_data", o_data, 0);
        check("t1_pop_level", o_level, 0);

        // 2. Fill to full, drop one, drain in order
        for (int k = 1; k <= 4; k++) push_word(8'(k));
        check("t2_ready", o_ready, 0);
        check("t2_level", o_level, 4);
        push_word(8'h05);
        check("t2_ovf", o_overflow, 1);
        check("t2_drop", o_drop_cnt, 1);
        check("t2_level_after_drop", o_level, 4);
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t2_drain", o_data, 32'(k));
            step();
        end
        i_ready = 1'b0;
        check("t2_empty", o_valid, 0);

        // 3. Push at full with same-cycle pop: word still dropped
        for (int k = 0; k < 4; k++) push_word(8'h31 + 8'(k));
        i_data  = 8'h99;
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        check("t3_drop", o_drop_cnt, 2);
        check("t3_level", o_level, 3);
        for (int k = 1; k < 4; k++) begin
            check("t3_drain", o_data, 32'h31 + 32'(k));
            step();
        end
        i_ready = 1'b0;
        check("t3_empty", o_valid, 0);

        // 4. Streaming with continuous pop, wraps pointers several times
        i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_data  = 8'h10 + 8'(k);
            i_valid = 1'b1;
            step();
            check("t4_data", o_data, 32'h10 + 32'(k));
            check("t4_level", o_level, 1);
        end
        i_valid = 1'b0;
        step();
        i_ready = 1'b0;
        check("t4_empty", o_valid, 0);
        check("t4_nodrop", o_drop_cnt, 2);

        // 5. Saturation and clear
        for (int k = 0; k < 4; k++) push_word(8'h40 + 8'(k));
        i_data  = 8'hEE;
        i_valid = 1'b1;
        for (int k = 0; k < 260; k++) step();
        i_valid = 1'b0;
        check("t5_sat", o_drop_cnt, 255);
        check("t5_ovf", o_overflow, 1);
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        check("t5_clr_ovf", o_overflow, 0);
        check("t5_clr_drop", o_drop_cnt, 0);
        i_valid   = 1'b1;
        i_ovf_clr = 1'b1;
        step();
        i_valid   = 1'b0;
        i_ovf_clr = 1'b0;
        check("t5_clrdrop_ovf", o_overflow, 1);
        check("t5_clrdrop_cnt", o_drop_cnt, 1);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5_drain", o_data, 32'h40 + 32'(k));
            step();
        end
        i_ready = 1'b0;
        check("t5_empty", o_valid, 0);

        // 6. Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) push_word(8'h50 + 8'(k));
        check("t6_level_pre", o_level, 3);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_level", o_level, 0);
        check("t6_rst_ready", o_ready, 1);
        check("t6_rst_ovf", o_overflow, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        push_word(8'h77);
        check("t6_new_data", o_data, 8'h77);
        check("t6_new_level", o_level, 1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("t6_final_empty", o_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
